// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit nibble per clock, LSB nibble first.
// Each nibble uses a carry-select pair (borrow-in 0 and 1) picked by the registered borrow.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic [3:0] nib_a, nib_b;
   logic [4:0] sub_b0, sub_b1, sub_sel;
   logic       last_step;

   // Nibble datapath: both borrow-in cases are formed, the registered borrow selects.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CW'(i)) begin
            nib_a = a_q[4*i +: 4];
            nib_b = b_q[4*i +: 4];
         end
      end
      sub_b0    = {1'b0, nib_a} - {1'b0, nib_b};
      sub_b1    = {1'b0, nib_a} - {1'b0, nib_b} - 5'd1;
      sub_sel   = brw_q ? sub_b1 : sub_b0;
      last_step = (cnt_q == CW'(N - 1));
   end

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (cnt_q == CW'(i)) diff_d[4*i +: 4] = sub_sel[3:0];
            end
            brw_d = sub_sel[4];
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               cnt_d   = '0;
               bout_d  = sub_sel[4];
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_sel[3] != a_q[WIDTH-1]);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign diff  = diff_q;
   assign bout  = bout_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed cases, handshake corner cases, and random
// operations compared against an arithmetic reference model.
module tb_nibble_serial_subtractor;

   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             bin;
   logic             ready, busy, done;
   logic [WIDTH-1:0] diff;
   logic             bout, ovf;

   int n_checks = 0;
   int n_errors = 0;

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of run, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: whole-word unsigned and signed arithmetic.
   task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                        output logic [15:0] md, output logic mbo, output logic mov);
      logic [16:0] u;
      int          s;
      u   = {1'b0, ma} - {1'b0, mb} - 17'(mbin);
      md  = u[15:0];
      mbo = u[16];
      s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      mov = (s > 32767) || (s < -32768);
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                         input bit scramble, input string tag);
      logic [15:0] ed;
      logic        eb, eo;
      int          lat, nbusy;
      model(ta, tb_, tbin, ed, eb, eo);
      lat = 0;
      while (!ready && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_ready_in"}, ready, 1);
      a = ta; b = tb_; bin = tbin; start = 1'b1;
      tick();
      start = 1'b0;
      if (scramble) begin
         a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      end
      lat = 0; nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, N);
      check({tag, "_busy_cycles"}, nbusy, N);
      check({tag, "_diff"}, diff, ed);
      check({tag, "_bout"}, bout, eb);
      check({tag, "_ovf"}, ovf, eo);
      tick();
      check({tag, "_ready_after"}, ready, 1);
      check({tag, "_done_single"}, done, 0);
   endtask

   initial begin
      int          ndone, ncyc;
      logic [15:0] cap;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      tick();
      tick();
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick();

      run_op(16'h1234, 16'h0034, 1'b0, 0, "basic");
      run_op(16'h0000, 16'h0001, 1'b0, 0, "ripple");
      run_op(16'h8000, 16'h0001, 1'b0, 0, "ovf_neg");
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, "ovf_pos");
      run_op(16'h0005, 16'h0005, 1'b1, 0, "bin_eq");
      run_op(16'hA5C3, 16'h3C5A, 1'b1, 1, "scramble");

      // start held through RUN and DONE: exactly one done, re-accept only after ready.
      a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
      tick();
      ndone = 0; ncyc = 0; cap = '0;
      while (!ready && ncyc < 20) begin
         if (done) begin
            ndone++;
            cap = diff;
         end
         tick();
         ncyc++;
      end
      check("hold_done_count", ndone, 1);
      check("hold_cycles", ncyc, N + 1);
      check("hold_diff", cap, 16'h000F);
      tick();
      check("hold_reaccept", busy, 1);
      start = 1'b0;
      ncyc = 0;
      while (!done && ncyc < 20) begin
         tick();
         ncyc++;
      end
      check("hold_second_diff", diff, 16'h000F);
      tick();

      // Reset during the 2nd RUN cycle aborts without a done.
      a = 16'hFFFF; b = 16'h1111; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort_in_run", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", ready, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_bout", bout, 0);
      check("abort_ovf", ovf, 0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) ndone++;
         tick();
      end
      check("abort_no_done", ndone, 0);

      for (int i = 0; i < 1000; i++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle two's-complement subtractor: diff = a - b - bin over WIDTH bits.
- Processes one 4-bit nibble per clock, LSB nibble first, rippling a registered borrow between nibbles.
- Each nibble stage uses a carry-select structure: both borrow-in cases are computed and the registered borrow selects the result.
- Serves as the subtract-side companion to the 4-bit carry-select adder. Used where area matters more than latency. Start/done handshake to the controlling FSM.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse; results are valid.
- diff  output  WIDTH  difference; held until the next accept.
- bout  output  1  borrow-out (1 when a < b + bin, unsigned).
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - ready=1, busy=0, done=0.
  - diff=0, bout=0, ovf=0, step counter=0.
  - Reset wins over every other event, including mid-RUN. An aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b, bin into internal registers. The borrow register takes bin; counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - k = counter. Compute {brw, d} = a_r[4k+3:4k] - b_r[4k+3:4k] - borrow_reg (5-bit result, brw = borrow).
  - Write d into diff[4k+3:4k] and brw into borrow_reg. Increment counter.
  - When k = N-1: go to DONE, set bout=brw, and set ovf = (a_r[MSB] != b_r[MSB]) && (d[3] != a_r[MSB]).
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE.
- Latency: done is high in the cycle after the N-th rising edge following the accepting edge. For WIDTH=16 that is 4 edges after accept. Throughput is one operation per N+2 cycles.
- start while busy or in DONE is ignored; no queuing.
- Earliest next accept is the edge ending the first IDLE cycle after done.
- Input changes after the accepting edge do not affect the result; operands are fully registered.
- diff nibbles not yet computed keep their previous values during RUN. The environment may rely on diff only while done=1 or afterwards, until the next accept.
- bout and ovf update only on the final RUN edge. They hold their previous values during RUN.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h0034, bin=0, start pulse in IDLE -> busy for 4 cycles, then done=1 for one cycle with diff=16'h1200, bout=0, ovf=0. ready returns to 1 the cycle after done.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0. The borrow ripples through all 4 nibbles.
- a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, ovf=1. Also a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, bout=1, ovf=1.
- a=16'h0005, b=16'h0005, bin=1 -> diff=16'hFFFF, bout=1, ovf=0. Separately, change a/b on the cycle after accept -> the result is unchanged.
- Start with a=16'h0010, b=16'h0001; assert start again for every cycle of RUN/DONE -> exactly one done with diff=16'h000F. The next accept occurs only after the ready=1 cycle.
- Assert rst on the 2nd RUN cycle -> the next cycle shows ready=1, busy=0, done=0, diff=0, bout=0, ovf=0, and no done pulse follows. Randomized 1000 operations vs reference a-b-bin -> all match.
